// File: rtl/id_ex_pipe_reg_if.sv
// ID->EX pipeline register bus: decode-side inputs, execute-side registered outputs.
// Master is the decode/control side, slave is the pipeline register itself.
interface id_ex_pipe_reg_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned REG_W  = 32,
  parameter int unsigned CMD_W  = 4,
  parameter int unsigned SHOP_W = 12,
  parameter int unsigned RA_W   = 4,
  parameter int unsigned CNT_W  = 16
);
  logic              flush;
  logic              freeze;
  logic              cnt_clr;
  logic              valid_in;
  logic [ADDR_W-1:0] pc_in;
  logic              mem_read_in;
  logic              mem_write_in;
  logic              wb_enable_in;
  logic              branch_taken_in;
  logic              status_write_enable_in;
  logic [CMD_W-1:0]  execute_command_in;
  logic [REG_W-1:0]  val_rn_in;
  logic [REG_W-1:0]  val_rm_in;
  logic              immediate_in;
  logic [23:0]       signed_immediate_in;
  logic [SHOP_W-1:0] shift_operand_in;
  logic [RA_W-1:0]   dest_in;
  logic [RA_W-1:0]   src1_in;
  logic [RA_W-1:0]   src2_in;
  logic [3:0]        status_in;

  logic              valid_out;
  logic [ADDR_W-1:0] pc_out;
  logic              mem_read_out;
  logic              mem_write_out;
  logic              wb_enable_out;
  logic              branch_taken_out;
  logic              status_write_enable_out;
  logic [CMD_W-1:0]  execute_command_out;
  logic [REG_W-1:0]  val_rn_out;
  logic [REG_W-1:0]  val_rm_out;
  logic              immediate_out;
  logic [23:0]       signed_immediate_out;
  logic [SHOP_W-1:0] shift_operand_out;
  logic [RA_W-1:0]   dest_out;
  logic [RA_W-1:0]   src1_out;
  logic [RA_W-1:0]   src2_out;
  logic [3:0]        status_out;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output flush, freeze, cnt_clr, valid_in, pc_in, mem_read_in, mem_write_in,
           wb_enable_in, branch_taken_in, status_write_enable_in, execute_command_in,
           val_rn_in, val_rm_in, immediate_in, signed_immediate_in, shift_operand_in,
           dest_in, src1_in, src2_in, status_in,
    input  valid_out, pc_out, mem_read_out, mem_write_out, wb_enable_out,
           branch_taken_out, status_write_enable_out, execute_command_out,
           val_rn_out, val_rm_out, immediate_out, signed_immediate_out,
           shift_operand_out, dest_out, src1_out, src2_out, status_out, bubble_cnt
  );

  modport slave (
    input  flush, freeze, cnt_clr, valid_in, pc_in, mem_read_in, mem_write_in,
           wb_enable_in, branch_taken_in, status_write_enable_in, execute_command_in,
           val_rn_in, val_rm_in, immediate_in, signed_immediate_in, shift_operand_in,
           dest_in, src1_in, src2_in, status_in,
    output valid_out, pc_out, mem_read_out, mem_write_out, wb_enable_out,
           branch_taken_out, status_write_enable_out, execute_command_out,
           val_rn_out, val_rm_out, immediate_out, signed_immediate_out,
           shift_operand_out, dest_out, src1_out, src2_out, status_out, bubble_cnt
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with flush/freeze, valid tracking and a saturating
// bubble counter used for pipeline-efficiency debug.
module id_ex_pipe_reg #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned REG_W  = 32,
  parameter int unsigned CMD_W  = 4,
  parameter int unsigned SHOP_W = 12,
  parameter int unsigned RA_W   = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  id_ex_pipe_reg_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic load_c;
  logic bubble_c;
  logic ctrl_keep_c;

  // A bubble enters EX when squashed, or when an empty slot is loaded.
  assign load_c      = !bus.flush && !bus.freeze;
  assign bubble_c    = bus.flush || (load_c && !bus.valid_in);
  assign ctrl_keep_c = bus.valid_in;

  // Entry registers: flush clears, freeze holds, otherwise load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.valid_out               <= 1'b0;
      bus.pc_out                  <= '0;
      bus.mem_read_out            <= 1'b0;
      bus.mem_write_out           <= 1'b0;
      bus.wb_enable_out           <= 1'b0;
      bus.branch_taken_out        <= 1'b0;
      bus.status_write_enable_out <= 1'b0;
      bus.execute_command_out     <= '0;
      bus.val_rn_out              <= '0;
      bus.val_rm_out              <= '0;
      bus.immediate_out           <= 1'b0;
      bus.signed_immediate_out    <= '0;
      bus.shift_operand_out       <= '0;
      bus.dest_out                <= '0;
      bus.src1_out                <= '0;
      bus.src2_out                <= '0;
      bus.status_out              <= '0;
    end else if (bus.flush) begin
      bus.valid_out               <= 1'b0;
      bus.pc_out                  <= '0;
      bus.mem_read_out            <= 1'b0;
      bus.mem_write_out           <= 1'b0;
      bus.wb_enable_out           <= 1'b0;
      bus.branch_taken_out        <= 1'b0;
      bus.status_write_enable_out <= 1'b0;
      bus.execute_command_out     <= '0;
      bus.val_rn_out              <= '0;
      bus.val_rm_out              <= '0;
      bus.immediate_out           <= 1'b0;
      bus.signed_immediate_out    <= '0;
      bus.shift_operand_out       <= '0;
      bus.dest_out                <= '0;
      bus.src1_out                <= '0;
      bus.src2_out                <= '0;
      bus.status_out              <= '0;
    end else if (!bus.freeze) begin
      bus.valid_out               <= bus.valid_in;
      bus.pc_out                  <= bus.pc_in;
      // Control is gated by valid so a bubble can never write or branch.
      bus.mem_read_out            <= bus.mem_read_in            && ctrl_keep_c;
      bus.mem_write_out           <= bus.mem_write_in           && ctrl_keep_c;
      bus.wb_enable_out           <= bus.wb_enable_in           && ctrl_keep_c;
      bus.branch_taken_out        <= bus.branch_taken_in        && ctrl_keep_c;
      bus.status_write_enable_out <= bus.status_write_enable_in && ctrl_keep_c;
      bus.execute_command_out     <= ctrl_keep_c ? bus.execute_command_in : '0;
      bus.val_rn_out              <= bus.val_rn_in;
      bus.val_rm_out              <= bus.val_rm_in;
      bus.immediate_out           <= bus.immediate_in;
      bus.signed_immediate_out    <= bus.signed_immediate_in;
      bus.shift_operand_out       <= bus.shift_operand_in;
      bus.dest_out                <= bus.dest_in;
      bus.src1_out                <= bus.src1_in;
      bus.src2_out                <= bus.src2_in;
      bus.status_out              <= bus.status_in;
    end
  end

  // Saturating bubble counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.bubble_cnt <= '0;
    end else if (bus.cnt_clr) begin
      bus.bubble_cnt <= '0;
    end else if (bubble_c && (bus.bubble_cnt != CNT_MAX)) begin
      bus.bubble_cnt <= bus.bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: a record-level model of the entry and bubble
// count is checked every cycle; a narrow-counter instance exercises saturation.
module tb_id_ex_pipe_reg;

  logic clk;
  logic rst;

  id_ex_pipe_reg_if #(.CNT_W(16)) bus ();
  id_ex_pipe_reg_if #(.CNT_W(4))  bus_s ();

  id_ex_pipe_reg #(.CNT_W(16)) dut   (.clk(clk), .rst(rst), .bus(bus));
  id_ex_pipe_reg #(.CNT_W(4))  dut_s (.clk(clk), .rst(rst), .bus(bus_s));

  // Narrow instance sees exactly the same stimulus.
  assign bus_s.flush                  = bus.flush;
  assign bus_s.freeze                 = bus.freeze;
  assign bus_s.cnt_clr                = bus.cnt_clr;
  assign bus_s.valid_in               = bus.valid_in;
  assign bus_s.pc_in                  = bus.pc_in;
  assign bus_s.mem_read_in            = bus.mem_read_in;
  assign bus_s.mem_write_in           = bus.mem_write_in;
  assign bus_s.wb_enable_in           = bus.wb_enable_in;
  assign bus_s.branch_taken_in        = bus.branch_taken_in;
  assign bus_s.status_write_enable_in = bus.status_write_enable_in;
  assign bus_s.execute_command_in     = bus.execute_command_in;
  assign bus_s.val_rn_in              = bus.val_rn_in;
  assign bus_s.val_rm_in              = bus.val_rm_in;
  assign bus_s.immediate_in           = bus.immediate_in;
  assign bus_s.signed_immediate_in    = bus.signed_immediate_in;
  assign bus_s.shift_operand_in       = bus.shift_operand_in;
  assign bus_s.dest_in                = bus.dest_in;
  assign bus_s.src1_in                = bus.src1_in;
  assign bus_s.src2_in                = bus.src2_in;
  assign bus_s.status_in              = bus.status_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // What EX should be holding, as a plain record.
  typedef struct {
    bit          valid;
    bit [31:0]   pc;
    bit          mr, mw, wb, br, sw;
    bit [3:0]    cmd;
    bit [31:0]   rn, rm;
    bit          imm;
    bit [23:0]   simm;
    bit [11:0]   shop;
    bit [3:0]    dest, s1, s2, st;
  } entry_t;

  entry_t m;
  int     cnt_m;
  int     cnt_s;
  int     n_vec;
  int     n_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic entry_t empty_entry();
    entry_t e;
    e = '{default: 0};
    return e;
  endfunction

  // Advance the model by one clock edge from the inputs currently applied.
  task automatic model_edge();
    bit is_bubble;
    is_bubble = 1'b0;
    if (bus.flush) begin
      m = empty_entry();
      is_bubble = 1'b1;
    end else if (bus.freeze) begin
      // entry unchanged, no bubble counted
    end else begin
      m.valid = bus.valid_in;
      m.pc    = bus.pc_in;
      m.rn    = bus.val_rn_in;
      m.rm    = bus.val_rm_in;
      m.imm   = bus.immediate_in;
      m.simm  = bus.signed_immediate_in;
      m.shop  = bus.shift_operand_in;
      m.dest  = bus.dest_in;
      m.s1    = bus.src1_in;
      m.s2    = bus.src2_in;
      m.st    = bus.status_in;
      if (bus.valid_in) begin
        m.mr  = bus.mem_read_in;
        m.mw  = bus.mem_write_in;
        m.wb  = bus.wb_enable_in;
        m.br  = bus.branch_taken_in;
        m.sw  = bus.status_write_enable_in;
        m.cmd = bus.execute_command_in;
      end else begin
        {m.mr, m.mw, m.wb, m.br, m.sw} = 5'b0;
        m.cmd = 4'd0;
        is_bubble = 1'b1;
      end
    end
    if (bus.cnt_clr) begin
      cnt_m = 0;
      cnt_s = 0;
    end else if (is_bubble) begin
      cnt_m = (cnt_m == 65535) ? 65535 : cnt_m + 1;
      cnt_s = (cnt_s == 15) ? 15 : cnt_s + 1;
    end
  endtask

  task automatic compare_all();
    check("valid_out",  64'(bus.valid_out),               64'(m.valid));
    check("pc_out",     64'(bus.pc_out),                  64'(m.pc));
    check("mem_read",   64'(bus.mem_read_out),            64'(m.mr));
    check("mem_write",  64'(bus.mem_write_out),           64'(m.mw));
    check("wb_enable",  64'(bus.wb_enable_out),           64'(m.wb));
    check("branch",     64'(bus.branch_taken_out),        64'(m.br));
    check("status_we",  64'(bus.status_write_enable_out), 64'(m.sw));
    check("exec_cmd",   64'(bus.execute_command_out),     64'(m.cmd));
    check("val_rn",     64'(bus.val_rn_out),              64'(m.rn));
    check("val_rm",     64'(bus.val_rm_out),              64'(m.rm));
    check("imm",        64'(bus.immediate_out),           64'(m.imm));
    check("simm",       64'(bus.signed_immediate_out),    64'(m.simm));
    check("shift_op",   64'(bus.shift_operand_out),       64'(m.shop));
    check("dest",       64'(bus.dest_out),                64'(m.dest));
    check("src1",       64'(bus.src1_out),                64'(m.s1));
    check("src2",       64'(bus.src2_out),                64'(m.s2));
    check("status",     64'(bus.status_out),              64'(m.st));
    check("bubble_cnt", 64'(bus.bubble_cnt),              64'(cnt_m));
    check("bubble_s",   64'(bus_s.bubble_cnt),            64'(cnt_s));
  endtask

  // One clock: model follows the edge, outputs compared at the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic clear_inputs();
    bus.flush = 0; bus.freeze = 0; bus.cnt_clr = 0; bus.valid_in = 0;
    bus.pc_in = '0; bus.mem_read_in = 0; bus.mem_write_in = 0; bus.wb_enable_in = 0;
    bus.branch_taken_in = 0; bus.status_write_enable_in = 0; bus.execute_command_in = '0;
    bus.val_rn_in = '0; bus.val_rm_in = '0; bus.immediate_in = 0;
    bus.signed_immediate_in = '0; bus.shift_operand_in = '0;
    bus.dest_in = '0; bus.src1_in = '0; bus.src2_in = '0; bus.status_in = '0;
  endtask

  task automatic load_full(input bit v, input logic [31:0] pc, input logic [3:0] cmd,
                           input logic [4:0] ctl, input logic [31:0] rn, input logic [31:0] rm);
    clear_inputs();
    bus.valid_in = v; bus.pc_in = pc; bus.execute_command_in = cmd;
    {bus.mem_read_in, bus.mem_write_in, bus.wb_enable_in,
     bus.branch_taken_in, bus.status_write_enable_in} = ctl;
    bus.val_rn_in = rn; bus.val_rm_in = rm; bus.immediate_in = pc[2];
    bus.signed_immediate_in = rn[23:0]; bus.shift_operand_in = rm[11:0];
    bus.dest_in = pc[5:2]; bus.src1_in = rn[3:0]; bus.src2_in = rm[3:0];
    bus.status_in = cmd ^ 4'hA;
  endtask

  initial begin
    n_vec = 0; n_err = 0; cnt_m = 0; cnt_s = 0;
    m = empty_entry();

    // Reset is asynchronous: assert with busy inputs before any rising edge.
    rst = 1'b1;
    load_full(1'b1, 32'hFFFF_FFFC, 4'hF, 5'b11111, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    bus.cnt_clr = 1'b0;
    #2 rst = 1'b0;
    #1 compare_all();
    check("rst_pc_lit", 64'(bus.pc_out), 64'h0);
    @(negedge clk);
    @(negedge clk);
    compare_all();

    // Plain load.
    clear_inputs();
    bus.valid_in = 1; bus.pc_in = 32'h40; bus.execute_command_in = 4'b0010;
    bus.wb_enable_in = 1; bus.dest_in = 4'd3;
    rst = 1'b1;
    step();
    check("load_pc_lit",    64'(bus.pc_out), 64'h40);
    check("load_cmd_lit",   64'(bus.execute_command_out), 64'h2);
    check("load_wb_lit",    64'(bus.wb_enable_out), 64'h1);
    check("load_valid_lit", 64'(bus.valid_out), 64'h1);
    check("load_cnt_lit",   64'(bus.bubble_cnt), 64'h0);

    // Freeze holds the entry while ID moves on.
    bus.freeze = 1;
    for (int i = 0; i < 3; i++) begin
      bus.pc_in = 32'h44 + 32'(4 * i);
      step();
    end
    check("frz_pc_lit",    64'(bus.pc_out), 64'h40);
    check("frz_valid_lit", 64'(bus.valid_out), 64'h1);
    check("frz_cnt_lit",   64'(bus.bubble_cnt), 64'h0);

    // Flush during freeze still squashes.
    bus.flush = 1; bus.mem_write_in = 1;
    step();
    check("fl_mw_lit",    64'(bus.mem_write_out), 64'h0);
    check("fl_wb_lit",    64'(bus.wb_enable_out), 64'h0);
    check("fl_valid_lit", 64'(bus.valid_out), 64'h0);
    check("fl_cnt_lit",   64'(bus.bubble_cnt), 64'h1);

    // Invalid load: data loads, control forced off.
    clear_inputs();
    bus.valid_in = 0; bus.mem_read_in = 1; bus.val_rn_in = 32'h1234;
    step();
    check("inv_mr_lit",    64'(bus.mem_read_out), 64'h0);
    check("inv_valid_lit", 64'(bus.valid_out), 64'h0);
    check("inv_rn_lit",    64'(bus.val_rn_out), 64'h1234);
    check("inv_cnt_lit",   64'(bus.bubble_cnt), 64'h2);

    // Mixed directed loads, including a frozen invalid slot (not a bubble).
    load_full(1'b1, 32'h0000_1000, 4'h9, 5'b10101, 32'h8000_0001, 32'h7FFF_FFFE); step();
    load_full(1'b1, 32'h0000_1004, 4'h4, 5'b01010, 32'h0F0F_0F0F, 32'hF0F0_F0F0); step();
    load_full(1'b0, 32'h0000_1008, 4'hC, 5'b11111, 32'h1111_2222, 32'h3333_4444);
    bus.freeze = 1; step();
    check("frz_inv_cnt_lit", 64'(bus.bubble_cnt), 64'h2);
    bus.freeze = 0; step();
    load_full(1'b1, 32'hFFFF_FFFC, 4'hF, 5'b11111, 32'hFFFF_FFFF, 32'h0); step();

    // Counter: clear, then drive the narrow counter to saturation.
    clear_inputs();
    bus.cnt_clr = 1; step();
    check("clr_cnt_lit", 64'(bus.bubble_cnt), 64'h0);
    bus.cnt_clr = 0; bus.flush = 1;
    for (int i = 0; i < 14; i++) step();
    check("sat_pre_lit", 64'(bus_s.bubble_cnt), 64'hE);
    for (int i = 0; i < 3; i++) step();
    check("sat_hold_lit", 64'(bus_s.bubble_cnt), 64'hF);
    check("wide_cnt_lit", 64'(bus.bubble_cnt), 64'd17);
    bus.cnt_clr = 1; step();
    check("clr_vs_inc_lit",   64'(bus.bubble_cnt), 64'h0);
    check("clr_vs_inc_s_lit", 64'(bus_s.bubble_cnt), 64'h0);
    clear_inputs();
    bus.valid_in = 1; bus.pc_in = 32'h80; step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
